// File: rtl/posit_adder_arbiter.sv
// Round-robin front end that shares one posit adder among R requesters and
// routes each result back to its originating requester via an in-order tag FIFO.
module posit_adder_arbiter #(
   parameter int  N   = 32,
   parameter int  R   = 4,
   parameter int  LAT = 0,
   localparam int IDW = $clog2(R),
   localparam int CW  = $clog2(LAT + 3)
) (
   input  logic             aclk,
   input  logic             reset,
   input  logic [R-1:0]     req_valid,
   output logic [R-1:0]     req_ready,
   input  logic [R*N-1:0]   req_in1,
   input  logic [R*N-1:0]   req_in2,
   output logic [N-1:0]     add_in1,
   output logic [N-1:0]     add_in2,
   output logic             add_start,
   input  logic [N-1:0]     add_result,
   input  logic             add_inf,
   input  logic             add_zero,
   input  logic             add_done,
   output logic [R-1:0]     rsp_valid,
   output logic [N-1:0]     rsp_result,
   output logic             rsp_inf,
   output logic             rsp_zero,
   output logic [CW-1:0]    inflight,
   output logic             err
);

   localparam int DEPTH = LAT + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [IDW-1:0] ID_LAST = IDW'(R - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } st_t;

   st_t              st_r;
   logic [IDW-1:0]   ptr_r;
   logic [IDW-1:0]   tag_mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    count_nxt_s;
   logic [IDW:0]     cand_s;
   logic [IDW-1:0]   grant_idx_s;
   logic             grant_found_s;
   logic             fifo_full_s;
   logic             issue_s;
   logic             pop_s;
   logic             op_cke_s;

   function automatic logic [R-1:0] onehot(input logic [IDW-1:0] idx);
      onehot = {{(R-1){1'b0}}, 1'b1} << idx;
   endfunction

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      next_ptr = (p == PTR_LAST) ? {PW{1'b0}} : p + {{(PW-1){1'b0}}, 1'b1};
   endfunction

   // first valid requester at or after ptr, wrapping modulo R
   always_comb begin
      grant_found_s = 1'b0;
      grant_idx_s   = {IDW{1'b0}};
      cand_s        = {(IDW+1){1'b0}};
      for (int i = 0; i < R; i++) begin
         cand_s = {1'b0, ptr_r} + (IDW+1)'(i);
         if (cand_s >= (IDW+1)'(R)) begin
            cand_s = cand_s - (IDW+1)'(R);
         end else begin
            cand_s = cand_s;
         end
         if (!grant_found_s && req_valid[cand_s[IDW-1:0]]) begin
            grant_found_s = 1'b1;
            grant_idx_s   = cand_s[IDW-1:0];
         end else begin
            grant_found_s = grant_found_s;
         end
      end
   end

   assign fifo_full_s = (count_r == CNT_FULL);
   assign issue_s     = grant_found_s & ~fifo_full_s & ~reset;
   assign pop_s       = add_done & (count_r != CNT_ZERO);
   assign op_cke_s    = (st_r == ST_BUSY) | (|req_valid);
   assign req_ready   = issue_s ? onehot(grant_idx_s) : {R{1'b0}};
   assign inflight    = count_r;

   // occupancy after this edge's push/pop
   always_comb begin
      case ({issue_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_ONE;
         2'b01:   count_nxt_s = count_r - CNT_ONE;
         default: count_nxt_s = count_r;
      endcase
   end

   // issue path, tag FIFO, response registers and sticky error
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         ptr_r      <= {IDW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         count_r    <= CNT_ZERO;
         add_start  <= 1'b0;
         add_in1    <= {N{1'b0}};
         add_in2    <= {N{1'b0}};
         rsp_valid  <= {R{1'b0}};
         rsp_result <= {N{1'b0}};
         rsp_inf    <= 1'b0;
         rsp_zero   <= 1'b0;
         err        <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_mem_r[i] <= {IDW{1'b0}};
         end
      end else begin
         add_start <= issue_s;
         count_r   <= count_nxt_s;
         if (issue_s) begin
            tag_mem_r[wr_ptr_r] <= grant_idx_s;
            wr_ptr_r            <= next_ptr(wr_ptr_r);
            ptr_r               <= (grant_idx_s == ID_LAST) ? {IDW{1'b0}}
                                   : grant_idx_s + {{(IDW-1){1'b0}}, 1'b1};
         end
         // operand bank only toggles while the block is active
         if (op_cke_s && issue_s) begin
            add_in1 <= req_in1[grant_idx_s*N +: N];
            add_in2 <= req_in2[grant_idx_s*N +: N];
         end
         if (pop_s) begin
            rd_ptr_r   <= next_ptr(rd_ptr_r);
            rsp_valid  <= onehot(tag_mem_r[rd_ptr_r]);
            rsp_result <= add_result;
            rsp_inf    <= add_inf;
            rsp_zero   <= add_zero;
         end else begin
            rsp_valid  <= {R{1'b0}};
         end
         if (add_done && count_r == CNT_ZERO) begin
            err <= 1'b1;
         end
      end
   end

   // idle/busy tracking; BUSY drops once the last result retires with no new issue
   always_ff @(posedge aclk or posedge reset) begin
      if (reset) begin
         st_r <= ST_IDLE;
      end else begin
         case (st_r)
            ST_IDLE: if (issue_s) st_r <= ST_BUSY;
            ST_BUSY: if (!issue_s && count_nxt_s == CNT_ZERO) st_r <= ST_IDLE;
            default: st_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/posit_adder_arbiter.md
# posit_adder_arbiter

Round-robin scheduler that shares one posit adder among R requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one operation per cycle. It tracks each in-flight operation's requester ID through the adder's latency and returns the result to the originating requester as a one-hot valid pulse. It sits between the PairHMM processing-element request ports and a single `posit_adder` instance.

## Interface
- `N`, 32, posit word width; must match the adder.
- `R`, 4, number of requesters; 2..16.
- `LAT`, 0, adder latency in cycles from `add_start` to `add_done`; 0..8.
- `IDW`, log2(R), requester ID width; derived, not overridden.
- `aclk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  R  per-requester operand valid.
- `req_ready`  out  R  per-requester accept; at most one bit set.
- `req_in1`, `req_in2`  in  R*N  operands; requester i occupies bits [i*N +: N].
- `add_in1`, `add_in2`  out  N  registered operands to the adder.
- `add_start`  out  1  one-cycle issue pulse to the adder.
- `add_result`  in  N  adder result.
- `add_inf`, `add_zero`  in  1  adder flags.
- `add_done`  in  1  adder completion strobe.
- `rsp_valid`  out  R  one-hot, one-cycle result pulse to the owning requester.
- `rsp_result`  out  N  result word, shared by all requesters.
- `rsp_inf`, `rsp_zero`  out  1  flags, valid with `rsp_valid`.
- `inflight`  out  log2(LAT+3)  number of issued operations not yet returned.
- `err`  out  1  sticky; set when `add_done` arrives with no operation in flight.

## Operation
- **Arbitration (combinational):**
  - Search `req_valid` starting at priority pointer `ptr` and wrapping modulo R.
  - Assert `req_ready` for the first valid requester `g` only.
  - If no request is valid, `req_ready` = 0.
- **Issue:** on the edge where `req_valid[g] & req_ready[g]`:
  - Register `req_in1[g]` and `req_in2[g]` into `add_in1`/`add_in2`.
  - Drive `add_start` = 1 for the next cycle only.
  - Push `g` into the tag FIFO.
  - Set `ptr` to (g+1) mod R.
- **No issue:** `ptr`, `add_in1` and `add_in2` hold; `add_start` = 0.
- **Tag FIFO:**
  - In-order, depth LAT+2.
  - Occupancy is driven on `inflight`.
  - The block never issues when the FIFO is full; `req_ready` is forced to 0.
  - With a correct adder the FIFO never fills, because completions retire one per cycle.
- **Completion:** on an edge with `add_done` = 1 and FIFO non-empty:
  - Pop tag `t`.
  - Register `rsp_result`/`rsp_inf`/`rsp_zero` from the adder outputs.
  - Drive `rsp_valid` = (1 << t) for one cycle.
- **Spurious completion:** `add_done` with FIFO empty sets `err`, leaves the FIFO unchanged and does not pulse `rsp_valid`. `err` clears only on reset.
- **Simultaneous push and pop:** both take effect in the same cycle; occupancy is unchanged.
- **Responses:** no backpressure; consumers must sample `rsp_*` on the pulse.
- **FSM `st`:**
  - IDLE: `inflight` = 0 and no request pending.
  - BUSY: otherwise.
  - IDLE→BUSY on the first issue; BUSY→IDLE on the cycle `inflight` returns to 0 with no issue.
  - `st` is observable only through `inflight`; it gates an optional clock-enable on the operand registers.

## Timing
- **Reset values:** `req_ready` = 0 while `reset` is high; `add_start` = 0; `add_in1`/`add_in2` = 0; `rsp_valid` = 0; `rsp_result` = 0; `rsp_inf` = 0; `rsp_zero` = 0; `inflight` = 0; `err` = 0; `ptr` = 0.
- **Latency:** handshake at edge k → `add_start` high in cycle k+1 → `add_done` at k+1+LAT → `rsp_valid` high in cycle k+2+LAT.
- **Throughput:** one issue per cycle sustained; back-to-back results from different requesters appear on consecutive cycles.
- **Reset mid-operation:**
  - In-flight tags are discarded.
  - Any `add_done` arriving after reset release with an empty FIFO sets `err`. The integrator holds the adder's start low through reset so that this does not happen.
- **Operand stability:** `req_in*` are sampled only on the accepting edge; they may change afterwards.

## Test plan
- **Single request, LAT=0:** requester 2 offers 0x40000000 + 0x40000000 → `req_ready[2]` in the same cycle; `add_start` one cycle later; `rsp_valid` = 4'b0100 two cycles after the handshake, carrying the adder's result.
- **Round-robin fairness:** all 4 requesters hold valid continuously → grants in order 0,1,2,3,0,1…, one per cycle; `rsp_valid` pulses in the same order, LAT+2 cycles after each grant.
- **Pipelined adder, LAT=3, 5 back-to-back issues:** `inflight` climbs to 4, then holds at 4 while completions overlap issues; every result is routed to the tag that issued it; `err` = 0.
- **Spurious `add_done`** with `inflight` = 0 → `err` = 1 and stays 1; no `rsp_valid`.
- **Reset asserted with 3 operations in flight:** all outputs go to reset values immediately (asynchronously); after release the first grant goes to requester 0.
- **Gap in requests:** requester 1 idle, requesters 0 and 3 valid with `ptr` = 1 → requester 3 granted first, then requester 0.
